// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types and helpers for the APB register-memory completer.
//   apb_state_e    : completer FSM states (IDLE, WAIT, READY)
//   APB_WORD_BYTES : bytes per data word
//   APB_ADDR_LSB   : bit position of the word index inside a byte address
//   addr_err()     : flags misaligned or out-of-range byte addresses
// ---------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_state_e;

    localparam int unsigned APB_WORD_BYTES = 32'd4;
    localparam int unsigned APB_ADDR_LSB   = 32'd2;

    // An access is in error when it is not word aligned or points past the last word.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        logic misaligned_s;
        logic out_of_range_s;
        misaligned_s   = ((addr % APB_WORD_BYTES) != 32'd0);
        out_of_range_s = ((addr >> APB_ADDR_LSB) >= depth);
        return misaligned_s | out_of_range_s;
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// ---------------------------------------------------------------------------
// apb_wait_ctr
// Loadable down-counter that times the wait states of one APB transfer.
//   PCLK, PRESET : clock, asynchronous active-high reset
//   load         : load load_val (takes priority over dec)
//   load_val     : number of wait states for the transfer
//   dec          : decrement request (ignored once the count is zero)
//   zero_next    : count is 1, so the next decrement reaches zero
// ---------------------------------------------------------------------------
module apb_wait_ctr #(
    parameter int WAIT_WIDTH = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  load,
    input  logic [WAIT_WIDTH-1:0] load_val,
    input  logic                  dec,
    output logic                  zero_next
);

    localparam logic [WAIT_WIDTH-1:0] CNT_ZERO = {WAIT_WIDTH{1'b0}};
    localparam logic [WAIT_WIDTH-1:0] CNT_ONE  = {{(WAIT_WIDTH-1){1'b0}}, 1'b1};

    logic [WAIT_WIDTH-1:0] cnt_r;

    // Wait-state count register: load at setup, count down in the access phase.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Not gated by dec so the FSM can combine it with its own decrement condition.
    assign zero_next = (cnt_r == CNT_ONE);

endmodule

// File: rtl/apb_slave_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_mem
// APB3 completer backed by a word-addressed register memory, with a
// programmable number of wait states per transfer and PSLVERR on misaligned
// or out-of-range addresses.
//   PCLK, PRESET     : clock, asynchronous active-high reset
//   PSEL, PENABLE    : APB select / access-phase strobe
//   PWRITE, PADDR    : direction and byte address (latched in the setup cycle)
//   PWDATA           : write data (latched in the setup cycle)
//   wait_cfg         : wait states for the transfer (latched in the setup cycle)
//   PRDATA           : read data, valid while PREADY=1, held until next result
//   PREADY, PSLVERR  : registered completion / error response
//   xfer_done        : one-cycle pulse after a transfer completes
// ---------------------------------------------------------------------------
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int WAIT_WIDTH = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [WAIT_WIDTH-1:0] wait_cfg,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  xfer_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    apb_state_e            state_r, state_s;
    logic [IDX_W-1:0]      idx_r;
    logic                  write_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  err_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [DATA_WIDTH-1:0] prdata_r, prdata_s;
    logic                  pready_r, pready_s;
    logic                  pslverr_r, pslverr_s;
    logic                  xfer_done_r, xfer_done_s;

    logic                  setup_s;
    logic                  new_err_s;
    logic [IDX_W-1:0]      new_idx_s;
    logic                  latch_s;
    logic                  load_s;
    logic                  dec_s;
    logic                  zero_next_s;
    logic                  mem_we_s;

    assign setup_s   = PSEL & ~PENABLE;
    assign new_err_s = addr_err(32'(PADDR), DEPTH);
    assign new_idx_s = PADDR[APB_ADDR_LSB +: IDX_W];

    apb_wait_ctr #(
        .WAIT_WIDTH (WAIT_WIDTH)
    ) u_wait_ctr (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .load      (load_s),
        .load_val  (wait_cfg),
        .dec       (dec_s),
        .zero_next (zero_next_s)
    );

    // Next-state and next-output logic of the transfer FSM.
    always_comb begin
        state_s     = state_r;
        latch_s     = 1'b0;
        load_s      = 1'b0;
        dec_s       = 1'b0;
        mem_we_s    = 1'b0;
        pready_s    = pready_r;
        pslverr_s   = pslverr_r;
        prdata_s    = prdata_r;
        xfer_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (setup_s) begin
                    latch_s = 1'b1;
                    load_s  = 1'b1;
                    if (wait_cfg == {WAIT_WIDTH{1'b0}}) begin
                        // Zero wait states: the result is formed straight from the bus values.
                        state_s   = READY;
                        pready_s  = 1'b1;
                        pslverr_s = new_err_s;
                        if (!PWRITE && !new_err_s) begin
                            prdata_s = mem_r[new_idx_s];
                        end else begin
                            prdata_s = DATA_ZERO;
                        end
                    end else begin
                        state_s  = WAIT;
                        pready_s = 1'b0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_s   = IDLE;
                    pready_s  = 1'b0;
                    pslverr_s = 1'b0;
                end else if (PENABLE) begin
                    dec_s = 1'b1;
                    if (zero_next_s) begin
                        state_s   = READY;
                        pready_s  = 1'b1;
                        pslverr_s = err_r;
                        if (!write_r && !err_r) begin
                            prdata_s = mem_r[idx_r];
                        end else begin
                            prdata_s = DATA_ZERO;
                        end
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            READY: begin
                if (!PSEL) begin
                    state_s   = IDLE;
                    pready_s  = 1'b0;
                    pslverr_s = 1'b0;
                end else if (PENABLE) begin
                    mem_we_s    = write_r & ~err_r;
                    state_s     = IDLE;
                    pready_s    = 1'b0;
                    pslverr_s   = 1'b0;
                    xfer_done_s = 1'b1;
                end else begin
                    state_s = READY;
                end
            end
            default: begin
                state_s   = IDLE;
                pready_s  = 1'b0;
                pslverr_s = 1'b0;
            end
        endcase
    end

    // FSM state and registered bus outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r     <= IDLE;
            pready_r    <= 1'b0;
            pslverr_r   <= 1'b0;
            prdata_r    <= DATA_ZERO;
            xfer_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            pready_r    <= pready_s;
            pslverr_r   <= pslverr_s;
            prdata_r    <= prdata_s;
            xfer_done_r <= xfer_done_s;
        end
    end

    // Setup-cycle capture of the transfer attributes; access-phase bus changes are ignored.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            idx_r   <= {IDX_W{1'b0}};
            write_r <= 1'b0;
            wdata_r <= DATA_ZERO;
            err_r   <= 1'b0;
        end else if (latch_s) begin
            idx_r   <= new_idx_s;
            write_r <= PWRITE;
            wdata_r <= PWDATA;
            err_r   <= new_err_s;
        end else begin
            idx_r   <= idx_r;
            write_r <= write_r;
            wdata_r <= wdata_r;
            err_r   <= err_r;
        end
    end

    // Register memory; written only on completion of an error-free write.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_ZERO;
            end
        end else if (mem_we_s) begin
            mem_r[idx_r] <= wdata_r;
        end else begin
            mem_r <= mem_r;
        end
    end

    assign PRDATA    = prdata_r;
    assign PREADY    = pready_r;
    assign PSLVERR   = pslverr_r;
    assign xfer_done = xfer_done_r;

endmodule
